zom_spawner: RTL and testbench

- Wave controller upstream of the per-slot zombie motion stages.
- Drives each slot's live flag and its spawn coordinates (start X, start Y).
- Schedules spawns on a frame-count interval and picks a lane with an LFSR.
- Tracks kills and end-of-lane events to declare the wave cleared or the game over.

---
 rtl/zom_spawner_if.sv | 26 ++
 rtl/zom_spawner.sv | 147 ++++++++++++++
 tb/tb_zom_spawner.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zom_spawner_if.sv
// rtl/zom_spawner_if.sv - slot bus between the wave spawner and the per-slot zombie motion stages
interface zom_spawner_if #(
    parameter int NUM_ZOM = 4
) ();
    logic [NUM_ZOM-1:0]    ZomLive;
    logic [10*NUM_ZOM-1:0] startX;
    logic [10*NUM_ZOM-1:0] startY;
    logic [NUM_ZOM-1:0]    zom_kill;
    logic [NUM_ZOM-1:0]    zom_end;

    modport master (
        output ZomLive,
        output startX,
        output startY,
        input  zom_kill,
        input  zom_end
    );

    modport slave (
        input  ZomLive,
        input  startX,
        input  startY,
        output zom_kill,
        output zom_end
    );
endinterface

// File: rtl/zom_spawner.sv
// rtl/zom_spawner.sv - wave controller: timed spawns into free slots, LFSR lane pick, clear/game-over tracking
module zom_spawner #(
    parameter int          NUM_ZOM        = 4,
    parameter int          NUM_LANES      = 5,
    parameter logic [9:0]  SPAWN_X        = 10'd639,
    parameter logic [9:0]  LANE_Y0        = 10'd80,
    parameter logic [9:0]  LANE_PITCH     = 10'd80,
    parameter int          FIRST_DELAY    = 180,
    parameter int          SPAWN_INTERVAL = 120,
    parameter int          WAVE_SIZE      = 10,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               game_start,
    input  logic               pause,
    zom_spawner_if.master      zif,
    output logic [7:0]         spawned_count,
    output logic               wave_done,
    output logic               game_over
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DELAY = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] OVER  = 3'd5;

    localparam logic [7:0] WAVE_W  = 8'(WAVE_SIZE);
    localparam logic [3:0] LANES_W = 4'(NUM_LANES);

    logic [2:0]              state;
    logic [15:0]             cnt;
    logic [7:0]              lfsr;
    logic [7:0]              lfsr_next;
    logic [NUM_ZOM-1:0][1:0] cooldown;
    logic [NUM_ZOM-1:0]      cd_busy;
    logic [NUM_ZOM-1:0]      free_mask;
    logic [NUM_ZOM-1:0]      spawn_onehot;
    logic [NUM_ZOM-1:0]      kill_mask;
    logic [2:0]              lane_r;
    logic [2:0]              lane;
    logic [9:0]              spawn_y;
    logic                    attempt;
    logic                    spawn_go;
    logic                    end_hit;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Lane codes past the last lane fold back onto the upper lanes.
    assign lane_r  = lfsr[2:0];
    assign lane    = ({1'b0, lane_r} < LANES_W) ? lane_r : lane_r - 3'(8 - NUM_LANES);
    assign spawn_y = LANE_Y0 + 10'(lane) * LANE_PITCH;

    always_comb begin
        cd_busy = '0;
        for (int i = 0; i < NUM_ZOM; i++) begin
            cd_busy[i] = (cooldown[i] != 2'd0);
        end
    end

    // Current-frame live bits gate eligibility, so a slot killed this frame cannot respawn yet.
    assign free_mask    = ~zif.ZomLive & ~cd_busy;
    assign spawn_onehot = free_mask & (~free_mask + NUM_ZOM'(1));
    assign kill_mask    = zif.zom_kill & zif.ZomLive;
    assign attempt      = (state == RUN) && !pause && (cnt == 16'd0);
    assign spawn_go     = attempt && (spawn_onehot != '0) && (spawned_count < WAVE_W);
    assign end_hit      = (state != IDLE) && (zif.zom_end != '0);

    assign wave_done = (state == DONE);
    assign game_over = (state == OVER);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            cnt           <= 16'd0;
            lfsr          <= LFSR_SEED;
            cooldown      <= '0;
            spawned_count <= 8'd0;
            zif.ZomLive   <= '0;
            zif.startX    <= '0;
            zif.startY    <= '0;
        end else if (end_hit || state == OVER) begin
            state       <= OVER;
            zif.ZomLive <= '0;
        end else begin
            for (int i = 0; i < NUM_ZOM; i++) begin
                if (kill_mask[i]) begin
                    zif.ZomLive[i] <= 1'b0;
                    cooldown[i]    <= 2'd2;
                end else if (!pause && cd_busy[i]) begin
                    cooldown[i] <= cooldown[i] - 2'd1;
                end
                if (spawn_go && spawn_onehot[i]) begin
                    zif.ZomLive[i]         <= 1'b1;
                    zif.startX[10*i +: 10] <= SPAWN_X;
                    zif.startY[10*i +: 10] <= spawn_y;
                end
            end
            if (spawn_go) begin
                spawned_count <= spawned_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (game_start) begin
                        state <= DELAY;
                        cnt   <= 16'(FIRST_DELAY - 1);
                    end
                end
                DELAY: begin
                    if (!pause) begin
                        lfsr <= lfsr_next;
                        if (cnt == 16'd0) begin
                            state <= RUN;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                RUN: begin
                    if (spawned_count >= WAVE_W) begin
                        state <= DRAIN;
                    end else if (!pause) begin
                        lfsr <= lfsr_next;
                        if (cnt == 16'd0) begin
                            cnt <= 16'(SPAWN_INTERVAL - 1);
                            if (spawn_go && (spawned_count + 8'd1 == WAVE_W)) begin
                                state <= DRAIN;
                            end
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (zif.ZomLive == '0) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zom_spawner.sv
// tb/tb_zom_spawner.sv - directed self-checking bench for zom_spawner
module tb_zom_spawner;
    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       game_start = 1'b0;
    logic       pause      = 1'b0;
    logic [7:0] spawned_count;
    logic       wave_done;
    logic       game_over;

    int n_checks = 0;
    int n_pass   = 0;

    zom_spawner_if #(.NUM_ZOM(4)) zif ();

    zom_spawner dut (
        .frame_clk     (frame_clk),
        .Reset_n       (Reset_n),
        .game_start    (game_start),
        .pause         (pause),
        .zif           (zif),
        .spawned_count (spawned_count),
        .wave_done     (wave_done),
        .game_over     (game_over)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Seed stepped n times through x^8+x^6+x^5+x^4+1, then mapped to a lane start Y.
    function automatic logic [9:0] exp_y(input int n);
        logic [7:0] l;
        logic [2:0] r;
        logic [2:0] lane;
        l = 8'hA5;
        for (int k = 0; k < n; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        r = l[2:0];
        lane = (r < 3'd5) ? r : r - 3'd3;
        return 10'd80 + 10'(lane) * 10'd80;
    endfunction

    function automatic logic [9:0] slot_x(input int s);
        logic [39:0] v;
        v = zif.startX;
        return v[10*s +: 10];
    endfunction

    function automatic logic [9:0] slot_y(input int s);
        logic [39:0] v;
        v = zif.startY;
        return v[10*s +: 10];
    endfunction

    task automatic apply_reset();
        Reset_n = 1'b0;
        game_start = 1'b0;
        pause = 1'b0;
        zif.zom_kill = 4'b0;
        zif.zom_end = 4'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        game_start = 1'b0;
        pause = 1'b0;
        zif.zom_kill = 4'b0;
        zif.zom_end = 4'b0;
        repeat (2) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0) $display("FAIL reset_live: got %b expected 0000", zif.ZomLive);
        else n_pass++;
        n_checks++;
        if (zif.startX !== 40'd0 || zif.startY !== 40'd0)
            $display("FAIL reset_start: got X=%h Y=%h expected 0", zif.startX, zif.startY);
        else n_pass++;
        n_checks++;
        if (spawned_count !== 8'd0 || wave_done !== 1'b0 || game_over !== 1'b0)
            $display("FAIL reset_status: got cnt=%0d done=%b over=%b expected 0/0/0", spawned_count, wave_done, game_over);
        else n_pass++;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_first_spawn();
        int early;
        early = 0;
        game_start = 1'b1;
        tick();
        for (int f = 1; f <= 180; f++) begin
            tick();
            if (zif.ZomLive !== 4'b0) early++;
        end
        n_checks++;
        if (early !== 0) $display("FAIL first_delay: got %0d live frames expected 0", early);
        else n_pass++;
        tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0001) $display("FAIL first_live: got %b expected 0001", zif.ZomLive);
        else n_pass++;
        n_checks++;
        if (slot_x(0) !== 10'd639) $display("FAIL first_x: got %0d expected 639", slot_x(0));
        else n_pass++;
        n_checks++;
        if (slot_y(0) !== exp_y(180)) $display("FAIL first_y: got %0d expected %0d", slot_y(0), exp_y(180));
        else n_pass++;
        n_checks++;
        if (spawned_count !== 8'd1) $display("FAIL first_count: got %0d expected 1", spawned_count);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [3:0] want;
        for (int k = 1; k <= 3; k++) begin
            repeat (120) tick();
            want = 4'((1 << (k + 1)) - 1);
            n_checks++;
            if (zif.ZomLive !== want) $display("FAIL fill_live%0d: got %b expected %b", k, zif.ZomLive, want);
            else n_pass++;
            n_checks++;
            if (slot_x(k) !== 10'd639 || slot_y(k) !== exp_y(180 + 120 * k))
                $display("FAIL fill_xy%0d: got %0d,%0d expected 639,%0d", k, slot_x(k), slot_y(k), exp_y(180 + 120 * k));
            else n_pass++;
        end
        n_checks++;
        if (spawned_count !== 8'd4) $display("FAIL fill_count: got %0d expected 4", spawned_count);
        else n_pass++;
        repeat (120) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b1111 || spawned_count !== 8'd4)
            $display("FAIL skip_full: got %b cnt=%0d expected 1111 cnt=4", zif.ZomLive, spawned_count);
        else n_pass++;
        n_checks++;
        if (slot_y(0) !== exp_y(180)) $display("FAIL hold_y0: got %0d expected %0d", slot_y(0), exp_y(180));
        else n_pass++;
    endtask

    task automatic test_kill_reuse();
        int relit;
        relit = 0;
        zif.zom_kill = 4'b0010;
        tick();
        zif.zom_kill = 4'b0000;
        n_checks++;
        if (zif.ZomLive !== 4'b1101) $display("FAIL kill_clear: got %b expected 1101", zif.ZomLive);
        else n_pass++;
        for (int t = 2; t <= 119; t++) begin
            tick();
            if (zif.ZomLive[1] !== 1'b0) relit++;
        end
        n_checks++;
        if (relit !== 0) $display("FAIL kill_hold: got %0d early frames expected 0", relit);
        else n_pass++;
        tick();
        n_checks++;
        if (zif.ZomLive !== 4'b1111 || spawned_count !== 8'd5)
            $display("FAIL kill_reuse: got %b cnt=%0d expected 1111 cnt=5", zif.ZomLive, spawned_count);
        else n_pass++;
        n_checks++;
        if (slot_y(1) !== exp_y(780)) $display("FAIL reuse_y: got %0d expected %0d", slot_y(1), exp_y(780));
        else n_pass++;
    endtask

    task automatic test_pause();
        zif.zom_kill = 4'b1000;
        tick();
        zif.zom_kill = 4'b0000;
        repeat (29) tick();
        pause = 1'b1;
        repeat (50) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0111 || spawned_count !== 8'd5)
            $display("FAIL pause_hold: got %b cnt=%0d expected 0111 cnt=5", zif.ZomLive, spawned_count);
        else n_pass++;
        pause = 1'b0;
        repeat (89) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0111) $display("FAIL pause_early: got %b expected 0111", zif.ZomLive);
        else n_pass++;
        tick();
        n_checks++;
        if (zif.ZomLive !== 4'b1111 || spawned_count !== 8'd6)
            $display("FAIL pause_shift: got %b cnt=%0d expected 1111 cnt=6", zif.ZomLive, spawned_count);
        else n_pass++;
        n_checks++;
        if (slot_y(3) !== exp_y(900)) $display("FAIL pause_lfsr: got %0d expected %0d", slot_y(3), exp_y(900));
        else n_pass++;
    endtask

    task automatic test_async_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (zif.ZomLive !== 4'b0 || zif.startX !== 40'd0 || zif.startY !== 40'd0 ||
            spawned_count !== 8'd0 || wave_done !== 1'b0 || game_over !== 1'b0)
            $display("FAIL async_reset: got live=%b cnt=%0d X=%h expected all 0", zif.ZomLive, spawned_count, zif.startX);
        else n_pass++;
        game_start = 1'b0;
        #2;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wave_done();
        int frame;
        int target;
        apply_reset();
        game_start = 1'b1;
        tick();
        frame = 0;
        for (int i = 1; i <= 10; i++) begin
            target = 181 + 120 * (i - 1);
            while (frame < target) begin
                tick();
                frame++;
            end
            n_checks++;
            if (zif.ZomLive !== 4'b0001 || spawned_count !== 8'(i) || slot_y(0) !== exp_y(target - 1))
                $display("FAIL wave_spawn%0d: got %b cnt=%0d y=%0d expected 0001 cnt=%0d y=%0d",
                         i, zif.ZomLive, spawned_count, slot_y(0), i, exp_y(target - 1));
            else n_pass++;
            zif.zom_kill = 4'b0001;
            tick();
            frame++;
            zif.zom_kill = 4'b0000;
        end
        n_checks++;
        if (zif.ZomLive !== 4'b0 || wave_done !== 1'b0)
            $display("FAIL drain_wait: got live=%b done=%b expected 0000 done=0", zif.ZomLive, wave_done);
        else n_pass++;
        tick();
        n_checks++;
        if (wave_done !== 1'b1) $display("FAIL wave_done: got %b expected 1", wave_done);
        else n_pass++;
        repeat (200) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0 || spawned_count !== 8'd10 || wave_done !== 1'b1 || game_over !== 1'b0)
            $display("FAIL done_hold: got live=%b cnt=%0d done=%b over=%b expected 0000/10/1/0",
                     zif.ZomLive, spawned_count, wave_done, game_over);
        else n_pass++;
    endtask

    task automatic test_game_over();
        apply_reset();
        game_start = 1'b1;
        tick();
        repeat (181) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0001) $display("FAIL over_pre: got %b expected 0001", zif.ZomLive);
        else n_pass++;
        repeat (10) tick();
        zif.zom_end = 4'b0100;
        zif.zom_kill = 4'b0001;
        tick();
        zif.zom_end = 4'b0000;
        zif.zom_kill = 4'b0000;
        n_checks++;
        if (game_over !== 1'b1 || wave_done !== 1'b0)
            $display("FAIL game_over: got over=%b done=%b expected 1/0", game_over, wave_done);
        else n_pass++;
        tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0) $display("FAIL over_live: got %b expected 0000", zif.ZomLive);
        else n_pass++;
        repeat (400) tick();
        n_checks++;
        if (zif.ZomLive !== 4'b0 || spawned_count !== 8'd1 || game_over !== 1'b1)
            $display("FAIL over_hold: got live=%b cnt=%0d over=%b expected 0000/1/1", zif.ZomLive, spawned_count, game_over);
        else n_pass++;
    endtask

    initial begin
        zif.zom_kill = 4'b0;
        zif.zom_end  = 4'b0;
        test_reset();
        test_first_spawn();
        test_fill();
        test_kill_reuse();
        test_pause();
        test_async_reset();
        test_wave_done();
        test_game_over();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
